// File: rtl/da_pkg.sv
// Shared constants, state encoding and small index helpers for the
// DA coefficient loader.
package da_pkg;

    localparam int NUM_ROMS  = 8;
    localparam int ROM_DEPTH = 256;
    localparam int CADDR_W   = 11;
    localparam int CIN_W     = 20;
    localparam int NUM_TAPS  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reflected binary Gray code of an 8-bit step index.
    function automatic logic [7:0] gray8(input logic [7:0] n);
        return n ^ (n >> 1);
    endfunction

    // Index of the lowest set bit; a zero input returns 0 and is never used.
    function automatic logic [2:0] tz8(input logic [7:0] v);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) res = 3'(i);
        end
        return res;
    endfunction

endpackage

// File: rtl/da_coef_loader_if.sv
// Host tap-write / load-control signals plus the coefficient stream to da.
interface da_coef_loader_if #(
    parameter int COEF_W = 16,
    parameter int CIN_W  = da_pkg::CIN_W
) ();

    logic                         coef_we;
    logic [5:0]                   coef_addr;
    logic signed [COEF_W-1:0]     coef_din;
    logic                         load_start;
    logic                         busy;
    logic                         load_done;
    logic [da_pkg::CADDR_W-1:0]   CADDR;
    logic signed [CIN_W-1:0]      CIN;
    logic                         CLOAD;
    logic                         valid_in;

    // Loader side: takes host requests, drives the ROM stream.
    modport master (
        input  coef_we, coef_addr, coef_din, load_start,
        output busy, load_done, CADDR, CIN, CLOAD, valid_in
    );

    // Host / da side.
    modport slave (
        output coef_we, coef_addr, coef_din, load_start,
        input  busy, load_done, CADDR, CIN, CLOAD, valid_in
    );

endinterface

// File: rtl/da_coef_regfile.sv
// 64-entry signed tap file: synchronous write, asynchronous clear,
// combinational read indexed by {g, j}.
module da_coef_regfile #(
    parameter int COEF_W = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     we,
    input  logic [5:0]               waddr,
    input  logic signed [COEF_W-1:0] wdata,
    input  logic [5:0]               raddr,
    output logic signed [COEF_W-1:0] rdata
);
    import da_pkg::*;

    logic signed [COEF_W-1:0] taps [NUM_TAPS];

    // Tap storage; reset returns every tap to zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_TAPS; i++) taps[i] <= '0;
        end else if (we) begin
            taps[waddr] <= wdata;
        end
    end

    assign rdata = taps[raddr];

endmodule

// File: rtl/da_coef_loader.sv
// Generates the 8 x 256 distributed-arithmetic partial sums from the tap
// file and streams them to da one entry per clock. Addresses walk Gray
// order inside each ROM so each step adds or removes exactly one tap.
module da_coef_loader #(
    parameter int COEF_W = 16,
    parameter int CIN_W  = da_pkg::CIN_W
) (
    input  logic             clk,
    input  logic             resetn,
    da_coef_loader_if.master bus
);
    import da_pkg::*;

    // COEF_W + 3 <= CIN_W keeps an 8-tap sum inside CIN_W, so no saturation.

    state_t state_q, state_d;

    logic [CADDR_W-1:0]       cnt_q, cnt_d;
    logic signed [CIN_W-1:0]  acc_q, acc_d;

    logic [2:0]               grp;
    logic [7:0]               idx, idx_nxt, gray_nxt;
    logic [2:0]               bit_j;
    logic signed [COEF_W-1:0] tap_rd;
    logic signed [CIN_W-1:0]  tap_ext;
    logic                     tap_we;

    logic [CADDR_W-1:0]       caddr_nxt, caddr_p1;
    logic signed [CIN_W-1:0]  cin_nxt, cin_p1;
    logic                     vld_nxt, vld_p1;
    logic                     busy_nxt, busy_p1;
    logic                     done_nxt, done_p1;

    assign grp      = cnt_q[CADDR_W-1:8];
    assign idx      = cnt_q[7:0];
    assign idx_nxt  = idx + 8'd1;
    assign gray_nxt = gray8(idx_nxt);
    assign bit_j    = tz8(idx_nxt);
    assign tap_we   = bus.coef_we && (state_q == IDLE);
    assign tap_ext  = {{(CIN_W-COEF_W){tap_rd[COEF_W-1]}}, tap_rd};

    da_coef_regfile #(.COEF_W(COEF_W)) u_regfile (
        .clk    (clk),
        .resetn (resetn),
        .we     (tap_we),
        .waddr  (bus.coef_addr),
        .wdata  (bus.coef_din),
        .raddr  ({grp, bit_j}),
        .rdata  (tap_rd)
    );

    // State, counter and accumulator registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Next state, Gray-walk running sum and next output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        caddr_nxt = '0;
        cin_nxt   = '0;
        vld_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            LOAD: begin
                caddr_nxt = {grp, gray8(idx)};
                cin_nxt   = acc_q;
                vld_nxt   = 1'b1;
                busy_nxt  = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (idx == 8'(ROM_DEPTH - 1)) begin
                    acc_d = '0;
                end else if (gray_nxt[bit_j]) begin
                    acc_d = acc_q + tap_ext;
                end else begin
                    acc_d = acc_q - tap_ext;
                end
                if (cnt_q == CADDR_W'(NUM_ROMS * ROM_DEPTH - 1)) state_d = DONE;
            end
            DONE: begin
                done_nxt = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- output register stage ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            caddr_p1 <= '0;
            cin_p1   <= '0;
            vld_p1   <= 1'b0;
            busy_p1  <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            caddr_p1 <= caddr_nxt;
            cin_p1   <= cin_nxt;
            vld_p1   <= vld_nxt;
            busy_p1  <= busy_nxt;
            done_p1  <= done_nxt;
        end
    end

    assign bus.CADDR     = caddr_p1;
    assign bus.CIN       = cin_p1;
    assign bus.CLOAD     = vld_p1;
    assign bus.valid_in  = vld_p1;
    assign bus.busy      = busy_p1;
    assign bus.load_done = done_p1;

endmodule

// File: tb/tb_da_coef_loader.sv
// Directed bench for da_coef_loader: tap patterns with hand-computed
// spot values and a per-address scoreboard built from a direct tap sum.
module tb_da_coef_loader;

    localparam int COEF_W = 16;
    localparam int CIN_W  = 20;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    da_coef_loader_if #(.COEF_W(COEF_W), .CIN_W(CIN_W)) bus ();

    da_coef_loader #(.COEF_W(COEF_W), .CIN_W(CIN_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int tap_m   [64];
    int sb      [2048];
    int got_cin [2048];
    bit seen    [2048];

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Entry value straight from its definition: sum of taps whose address bit is set.
    function automatic int model(input int addr);
        int g, a, s;
        g = addr >> 8;
        a = addr & 255;
        s = 0;
        for (int j = 0; j < 8; j++) if (((a >> j) & 1) == 1) s += tap_m[g*8 + j];
        return s;
    endfunction

    task automatic write_taps();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bus.coef_we   = 1'b1;
            bus.coef_addr = 6'(i);
            bus.coef_din  = 16'(tap_m[i]);
        end
        @(negedge clk);
        bus.coef_we = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_cload"}, bus.CLOAD, 0);
        check({tag, "_valid"}, bus.valid_in, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.load_done, 0);
        check({tag, "_caddr"}, bus.CADDR, 0);
        check({tag, "_cin"},   bus.CIN, 0);
    endtask

    // One full load; optional injected requests at an entry, a start
    // request during DONE, or a reset at a given entry.
    task automatic do_load(input int inj_at, input bit probe_done, input int abort_at);
        int nseen;
        nseen = 0;
        for (int a = 0; a < 2048; a++) begin
            sb[a]      = model(a);
            seen[a]    = 1'b0;
            got_cin[a] = 0;
        end
        @(negedge clk);
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        for (int cyc = 1; cyc <= 2051; cyc++) begin
            @(negedge clk);
            if (cyc <= 2048) begin
                int m, ea;
                m  = cyc - 1;
                ea = ((m >> 8) << 8) | ((m & 255) ^ ((m & 255) >> 1));
                check("cload", bus.CLOAD, 1);
                check("valid_in", bus.valid_in, 1);
                check("busy", bus.busy, 1);
                check("done_early", bus.load_done, 0);
                check("caddr", bus.CADDR, ea);
                check("cin", bus.CIN, sb[bus.CADDR]);
                if (!seen[bus.CADDR]) nseen++;
                seen[bus.CADDR]    = 1'b1;
                got_cin[bus.CADDR] = bus.CIN;
            end
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                resetn = 1'b0;
                #1;
                check_quiet("abort");
                return;
            end
            if (cyc == 2049) begin
                check("load_done", bus.load_done, 1);
                check("end_busy", bus.busy, 0);
                check("end_cload", bus.CLOAD, 0);
                check("end_valid", bus.valid_in, 0);
                check("end_caddr", bus.CADDR, 0);
                check("end_cin", bus.CIN, 0);
            end
            if (cyc >= 2050) begin
                check("post_done", bus.load_done, 0);
                check("post_cload", bus.CLOAD, 0);
                check("post_busy", bus.busy, 0);
            end
            if (inj_at >= 0 && cyc == inj_at + 1) begin
                bus.load_start = 1'b1;
                bus.coef_we    = 1'b1;
                bus.coef_addr  = 6'd0;
                bus.coef_din   = 16'sd99;
            end
            if (inj_at >= 0 && cyc == inj_at + 2) begin
                bus.load_start = 1'b0;
                bus.coef_we    = 1'b0;
            end
            if (probe_done && cyc == 2048) bus.load_start = 1'b1;
            if (probe_done && cyc == 2049) bus.load_start = 1'b0;
        end
        check("distinct_addrs", nseen, 2048);
    endtask

    initial begin
        resetn         = 1'b0;
        bus.load_start = 1'b1;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_din   = '0;

        // Reset held with load_start high: everything stays quiet.
        repeat (4) begin
            @(negedge clk);
            check_quiet("reset");
        end
        bus.load_start = 1'b0;
        resetn         = 1'b1;
        @(negedge clk);
        check_quiet("idle");

        // All taps 1: entries are popcounts.
        for (int i = 0; i < 64; i++) tap_m[i] = 1;
        write_taps();
        do_load(-1, 1'b1, -1);
        check("ones_000", got_cin[11'h000], 0);
        check("ones_3ff", got_cin[11'h3FF], 8);
        check("ones_780", got_cin[11'h780], 1);

        // Mixed signs: +2^j in even ROMs, -2^j in odd ROMs.
        for (int i = 0; i < 64; i++) tap_m[i] = (((i >> 3) % 2) == 0) ? (1 << (i % 8)) : -(1 << (i % 8));
        write_taps();
        do_load(-1, 1'b0, -1);
        check("mixed_0a5", got_cin[11'h0A5], 165);
        check("mixed_1ff", got_cin[11'h1FF], -255);

        // Negative extreme.
        for (int i = 0; i < 64; i++) tap_m[i] = -32768;
        write_taps();
        do_load(-1, 1'b0, -1);
        check("neg_7ff", got_cin[11'h7FF], -262144);

        // Positive extreme.
        for (int i = 0; i < 64; i++) tap_m[i] = 32767;
        write_taps();
        do_load(-1, 1'b0, -1);
        check("pos_0ff", got_cin[11'h0FF], 262136);
        check("pos_100", got_cin[11'h100], 0);

        // Start and tap write during a load are ignored; tap 0 stays +1.
        for (int i = 0; i < 64; i++) tap_m[i] = (((i >> 3) % 2) == 0) ? (1 << (i % 8)) : -(1 << (i % 8));
        write_taps();
        do_load(500, 1'b0, -1);
        do_load(-1, 1'b0, -1);
        check("old_tap0", got_cin[11'h001], 1);

        // Reset at entry 1000 aborts and clears the taps.
        do_load(-1, 1'b0, 1000);
        repeat (3) begin
            @(negedge clk);
            check_quiet("abort_hold");
        end
        resetn = 1'b1;
        for (int i = 0; i < 64; i++) tap_m[i] = 0;
        do_load(-1, 1'b0, -1);
        check("cleared_0ff", got_cin[11'h0FF], 0);

        for (int i = 0; i < 64; i++) tap_m[i] = 1;
        write_taps();
        do_load(-1, 1'b0, -1);
        check("reload_7ff", got_cin[11'h7FF], 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/da_coef_loader.md
# da_coef_loader

Initiator side of the DA coefficient-load interface. Holds 64 signed FIR taps written by a host, then generates all 2048 distributed-arithmetic partial-sum entries (8 ROMs × 256) and streams them to `da` over `CADDR`/`CIN`/`CLOAD`/`valid_in`, one entry per clock. Sits between the host register interface and `da`, and replaces the bench-side ROM preload.

## Interface

Parameters:
- `COEF_W`, default 16: signed tap width. Must satisfy `COEF_W + 3 <= CIN_W`.
- `CIN_W`, default 20: width of a ROM entry, matching `da.CIN`.

Ports:
- `clk`, input, 1: the single clock. All logic is rising-edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `coef_we`, input, 1: tap write strobe.
- `coef_addr`, input, 6: tap index t = 8·g + j, where g is the ROM and j is the address bit.
- `coef_din`, input, `COEF_W`: signed tap value.
- `load_start`, input, 1: starts a full ROM load. Sampled only in IDLE.
- `busy`, output, 1: high in LOAD.
- `load_done`, output, 1: one-cycle pulse after the last entry.
- `CADDR`, output, 11: `{g[2:0], a[7:0]}`.
- `CIN`, output, `CIN_W`: signed entry value.
- `CLOAD`, output, 1: entry-valid strobe to `da`.
- `valid_in`, output, 1: identical to `CLOAD`.

## Operation

- Tap file: 64 × `COEF_W` registers.
  - Written on `coef_we` only while in IDLE. Writes during LOAD or DONE are ignored.
  - Reset clears every tap to 0.
- Entry definition: ROM g, address a holds the sum of tap[8g+j] over every j where a[j] = 1.
  - Sign-extended to `CIN_W`.
  - No saturation is needed because the width rule guarantees no overflow.
- Address order: within a group, a walks Gray order, a_n = n ^ (n >> 1) for n = 0..255.
  - Groups are emitted in order g = 0..7.
  - Each `CADDR` value is issued exactly once per load.
- Running sum S:
  - S = 0 at n = 0 of every group.
  - For the step n → n+1, j = trailing-zero count of (n+1).
  - S += tap[8g+j] if bit j of a_{n+1} is 1, otherwise S −= tap[8g+j].
- FSM:
  - IDLE → LOAD on `load_start`.
  - LOAD → DONE after the entry g = 7, n = 255.
  - DONE → IDLE unconditionally.
  - `load_start` in LOAD or DONE is ignored.
- Counter: one 11-bit counter `{g, n}`. It is cleared on entry to LOAD.

## Timing

- Reset values: `busy`, `load_done`, `CLOAD`, `valid_in` = 0. `CADDR` = 0. `CIN` = 0. State = IDLE.
- Reset mid-load aborts immediately. No partial resume: the next `load_start` restarts at `CADDR` 0.
- All outputs are registered.
- Load sequence, with `load_start` high at edge k:
  - Edge k+1 presents entry 0: `CADDR` 0, `CIN` 0, `CLOAD` = `valid_in` = 1.
  - Entry m is presented after edge k+1+m.
  - The last entry, `CADDR` 0x780, is presented after edge k+2048.
- End of load:
  - After edge k+2049: `CLOAD` = 0, `CADDR` = 0, `CIN` = 0, `load_done` = 1, `busy` = 0.
  - The tap file becomes writable the cycle after DONE.
- `busy` is high from edge k+1 through the last entry cycle.
- Group boundary: after `CADDR` {g,0x80}, the next entry is {g+1,0x00} with `CIN` = 0 and no bubble.
- Back-to-back loads: `load_start` asserted in DONE is ignored. The earliest restart is the first IDLE cycle after DONE.

## Structure

- Package `da_pkg` holds:
  - `NUM_ROMS`=8, `ROM_DEPTH`=256, `CADDR_W`=11, `CIN_W`=20, `NUM_TAPS`=64.
  - The state enum `{IDLE, LOAD, DONE}`.
- Sub-module `da_coef_regfile`:
  - 64 × `COEF_W` registers.
  - Synchronous write, asynchronous clear.
  - Combinational read port indexed by {g, j}.
- Top level holds the FSM, the counter, Gray and trailing-zero logic, the add/subtract accumulator and the output registers.

## Test plan

- Reset: hold `resetn`=0 with `load_start`=1 → every output stays 0 and no `CLOAD` pulse appears.
- All taps = 1, then `load_start`:
  - Exactly 2048 `CLOAD` cycles, each address seen once, first `CADDR` = 0.
  - `CIN` = popcount(a) for every entry, e.g. `CADDR` 0x3FF → 8.
  - `load_done` pulses 2049 cycles after the `load_start` edge.
- Mixed-sign taps: tap[8g+j] = +2^j for even g and −2^j for odd g.
  - `CADDR` 0x0A5 → `CIN` 165.
  - `CADDR` 0x1FF → `CIN` −255 (20'hFFF01).
  - The bench checks against a scoreboard indexed by `CADDR`.
- Extremes:
  - All taps −32768 → `CADDR` 0x7FF gives `CIN` −262144 (20'hC0000).
  - All taps 32767 → `CADDR` 0x0FF gives `CIN` 262136.
  - `CADDR` 0x100 gives 0 (group reset).
- Ignored requests: pulse `load_start` and `coef_we` (tap 0 ← 99) at cycle 500 of a load.
  - The load completes unchanged in 2048 entries.
  - A following load still uses the old tap 0.
- Reset mid-load: assert `resetn`=0 at entry 1000.
  - Outputs are 0 asynchronously and taps are cleared.
  - After a re-write of the taps and a new `load_start`, the first `CADDR` is 0 and the full 2048-entry load completes.
